neuron_weight_update: RTL and testbench



---
 rtl/neuron_weight_update_if.sv | 21 ++
 rtl/neuron_weight_update.sv | 124 ++++++++++++
 tb/tb_neuron_weight_update.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_weight_update_if.sv
// Handshake bundle for neuron_weight_update: error term channel and input activation channel.
// Both channels transfer on a clock edge where valid and ready are both high; valid must not depend on ready.
interface neuron_weight_update_if;
  logic               err_valid;
  logic               err_ready;
  logic signed [16:0] err;
  logic        [3:0]  lr_shift;
  logic               x_valid;
  logic               x_ready;
  logic signed [7:0]  x;

  modport master (
    output err_valid, err, lr_shift, x_valid, x,
    input  err_ready, x_ready
  );

  modport slave (
    input  err_valid, err, lr_shift, x_valid, x,
    output err_ready, x_ready
  );
endinterface

// File: rtl/neuron_weight_update.sv
// One gradient step on N signed 8-bit weights plus bias: w += sat((err*x) >>> lr_shift), b += sat(err >>> lr_shift).
// Optional macro NEURON_UPD_ROUND_EN adds 2^(lr_shift-1) before each shift (round-half-up instead of floor).
module neuron_weight_update #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_weight_update_if.slave    bus,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic signed [7:0]        rd_w,
  output logic signed [7:0]        bias_out,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    BIAS   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic signed [16:0]     err_q, err_d;
  logic [3:0]             lr_q, lr_d;
  logic signed [7:0]      w_q [N];
  logic signed [7:0]      w_d [N];
  logic signed [7:0]      bias_q, bias_d;

  logic signed [24:0]     prod;
  logic signed [7:0]      w_cur;
  logic signed [7:0]      w_upd;
  logic signed [7:0]      bias_upd;

  // Shift toward zero-bias step size; the rounding offset only exists in the rounding build.
  function automatic logic signed [25:0] scale(input logic signed [25:0] v, input logic [3:0] sh);
    logic signed [25:0] r;
    r = v;
`ifdef NEURON_UPD_ROUND_EN
    if (sh != 4'd0) r = v + (26'sd1 <<< (sh - 4'd1));
`endif
    return r >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [25:0] v);
    if (v > 26'sd127)       return 8'sh7f;
    else if (v < -26'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  assign w_cur    = w_q[idx_q];
  assign prod     = {{8{err_q[16]}}, err_q} * {{17{bus.x[7]}}, bus.x};
  assign w_upd    = sat8({{18{w_cur[7]}}, w_cur} + scale({prod[24], prod}, lr_q));
  assign bias_upd = sat8({{18{bias_q[7]}}, bias_q} + scale({{9{err_q[16]}}, err_q}, lr_q));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    err_d         = err_q;
    lr_d          = lr_q;
    w_d           = w_q;
    bias_d        = bias_q;
    bus.err_ready = 1'b0;
    bus.x_ready   = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        busy          = 1'b0;
        bus.err_ready = 1'b1;
        if (bus.err_valid) begin
          err_d   = bus.err;
          lr_d    = bus.lr_shift;
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        bus.x_ready = 1'b1;
        if (bus.x_valid) begin
          w_d[idx_q] = w_upd;
          idx_d      = idx_q + 1'b1;
          if (idx_q == IDX_W'(N - 1)) state_d = BIAS;
        end
      end
      BIAS: begin
        bias_d  = bias_upd;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      lr_q    <= '0;
      bias_q  <= '0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      lr_q    <= lr_d;
      bias_q  <= bias_d;
      for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
    end
  end

  // Indices past the bank read as zero so the forward neuron sees no phantom weights.
  assign rd_w      = (32'(rd_idx) < N) ? w_q[rd_idx] : 8'sd0;
  assign bias_out  = bias_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_neuron_weight_update.sv
// Directed bench for neuron_weight_update: a driver issues updates, a monitor checks weights, bias and latency on done.
module tb_neuron_weight_update;
  localparam int N = 4;
  localparam int IDX_W = 2;

  logic               clk;
  logic               rst;
  logic [IDX_W-1:0]   rd_idx;
  logic signed [7:0]  rd_w;
  logic signed [7:0]  bias_out;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;

  neuron_weight_update_if bus();

  neuron_weight_update #(.N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .rd_idx    (rd_idx),
    .rd_w      (rd_w),
    .bias_out  (bias_out),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int acc_edge = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && bus.err_valid && bus.err_ready) acc_edge <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // {latency[47:40], bias[39:32], w3, w2, w1, w0}
  logic [47:0] exp_q[$];

  logic             mon_active = 1'b0;
  logic [IDX_W-1:0] mon_idx = '0;
  logic [IDX_W-1:0] main_idx = '0;
  assign rd_idx = mon_active ? mon_idx : main_idx;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] pk(input int lat, input int b, input int w0, input int w1,
                                     input int w2, input int w3);
    return {8'(lat), 8'(b), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endfunction

  // monitor / scoreboard
  initial begin
    logic [47:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        lat = cyc - acc_edge + 1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no update in flight (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          mon_active = 1'b1;
          for (int i = 0; i < N; i++) begin
            mon_idx = IDX_W'(i);
            #1;
            chk($sformatf("w%0d", i), int'(rd_w), int'($signed(e[8*i +: 8])));
          end
          mon_active = 1'b0;
          chk("bias", int'(bias_out), int'($signed(e[39:32])));
          chk("latency", lat, int'(e[47:40]));
          @(negedge clk);
          chk("done_width", int'(done), 0);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input int e, input int lr, input int x0, input int x1, input int x2,
                      input int x3, input logic [15:0] vpat, input int plen, input bit probe);
    int xs[4];
    int k;
    int n;
    xs = '{x0, x1, x2, x3};
    k = 0;
    n = 0;
    @(negedge clk);
    bus.err_valid = 1'b1;
    bus.err       = 17'(e);
    bus.lr_shift  = 4'(lr);
    while (!bus.err_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("err_accept_timeout", n, 0);
    @(negedge clk);
    bus.err_valid = 1'b0;
    for (int c = 0; c < plen; c++) begin
      if (vpat[c] && k < 4) begin
        bus.x_valid = 1'b1;
        bus.x       = 8'(xs[k]);
        k++;
      end else begin
        bus.x_valid = 1'b0;
        bus.x       = 8'sd99;
      end
      if (probe && c == 1) begin
        bus.err_valid = 1'b1;
        bus.err       = 17'sd500;
        chk("err_ready_in_update", int'(bus.err_ready), 0);
      end else begin
        bus.err_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.x_valid   = 1'b0;
    bus.err_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("done_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic chk_bank(input string tag, input int w0, input int w1, input int w2,
                          input int w3, input int b);
    int ws[4];
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      main_idx = IDX_W'(i);
      #1;
      chk($sformatf("%s_w%0d", tag, i), int'(rd_w), ws[i]);
    end
    chk({tag, "_bias"}, int'(bias_out), b);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err_ready"}, int'(bus.err_ready), 1);
    chk({tag, "_x_ready"}, int'(bus.x_ready), 0);
    chk({tag, "_state"}, int'(state_dbg), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // main stimulus
  initial begin
    rst           = 1'b1;
    bus.err_valid = 1'b0;
    bus.err       = '0;
    bus.lr_shift  = '0;
    bus.x_valid   = 1'b0;
    bus.x         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk_idle("reset");
    chk("reset_done", int'(done), 0);
    chk_bank("reset", 0, 0, 0, 0, 0);

    // basic step, back-to-back beats
    exp_q.push_back(pk(6, 4, 4, 8, -12, 0));
    send(16, 2, 1, 2, -3, 0, 16'b1111, 4, 1'b0);
    wait_idle();

    // saturation on both rails, then a repeat keeps them pinned
    exp_q.push_back(pk(6, 127, 127, -128, 127, 127));
    send(1000, 0, 127, -128, 1, 1, 16'b1111, 4, 1'b0);
    wait_idle();
    exp_q.push_back(pk(6, 127, 127, -128, 127, 127));
    send(1000, 0, 127, -128, 1, 1, 16'b1111, 4, 1'b0);
    wait_idle();

    do_reset();
    chk_bank("rst2", 0, 0, 0, 0, 0);

    // small negative step: floor gives -1, rounding gives 0
`ifdef NEURON_UPD_ROUND_EN
    exp_q.push_back(pk(6, 0, 0, 0, 0, 0));
`else
    exp_q.push_back(pk(6, -1, -1, -1, -1, -1));
`endif
    send(-1, 1, 1, 1, 1, 1, 16'b1111, 4, 1'b0);
    wait_idle();

    do_reset();

    // activations presented while IDLE must be ignored
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x       = 8'sd100;
    repeat (3) begin
      @(negedge clk);
      chk("x_ready_idle", int'(bus.x_ready), 0);
    end
    bus.x_valid = 1'b0;
    chk_bank("idle_x", 0, 0, 0, 0, 0);

    // backpressure with an err_valid probe during UPDATE
    exp_q.push_back(pk(9, 4, 4, 8, -12, 0));
    send(16, 2, 1, 2, -3, 0, 16'b1101001, 7, 1'b1);
    wait_idle();

    // zero error leaves everything alone
    exp_q.push_back(pk(6, 4, 4, 8, -12, 0));
    send(0, 0, 5, 5, 5, 5, 16'b1111, 4, 1'b0);
    wait_idle();

    // largest shift: tiny products floor to 0 / -1
`ifdef NEURON_UPD_ROUND_EN
    exp_q.push_back(pk(6, 4, 4, 8, -12, 0));
`else
    exp_q.push_back(pk(6, 4, 4, 7, -12, -1));
`endif
    send(1, 15, 1, -1, 1, -1, 16'b1111, 4, 1'b0);
    wait_idle();

    // abort after two beats
    send(16, 2, 1, 2, -3, 0, 16'b11, 2, 1'b0);
    chk("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_idle("abort");
    chk_bank("abort", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // fresh update after abort
    exp_q.push_back(pk(6, 4, 4, 8, -12, 0));
    send(16, 2, 1, 2, -3, 0, 16'b1111, 4, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
